// File: rtl/wand_bus_tx.sv
// Wired-AND bus transmitter: waits for an idle line, sends start/data/stop bits
// MSB first, and drops out as soon as a released '1' is read back as '0'.
module wand_bus_tx #(
   parameter int DATA_W      = 8,
   parameter int BIT_CYCLES  = 4,
   parameter int IDLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   input  logic              bus_in,
   output logic              bus_drive_low,
   output logic              done,
   output logic              arb_lost,
   output logic              frame_err,
   output logic [2:0]        state_dbg
);

   localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int IXW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CYCLES - 1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYCLES - 1);
   localparam logic [IXW-1:0] IDX_LAST  = IXW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_IDLE = 3'd1,
      S_START     = 3'd2,
      S_DATA      = 3'd3,
      S_STOP      = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [ICW-1:0]      idle_cnt_q, idle_cnt_d;
   logic [IXW-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                ev_done, ev_lost, ev_ferr;
   logic                sample;

   logic tx_ready_q, tx_ready_d;
   logic drive_q, drive_d;
   logic done_q, done_d;
   logic arb_lost_q, arb_lost_d;
   logic frame_err_q, frame_err_d;

   // Handshake: a payload transfers on any rising edge where tx_valid && tx_ready;
   // tx_ready is high only in IDLE and tx_valid is ignored everywhere else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         tx_ready_q  <= 1'b1;
         drive_q     <= 1'b0;
         done_q      <= 1'b0;
         arb_lost_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         tx_ready_q  <= tx_ready_d;
         drive_q     <= drive_d;
         done_q      <= done_d;
         arb_lost_q  <= arb_lost_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign sample = (bit_cnt_q == BIT_LAST);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      ev_done    = 1'b0;
      ev_lost    = 1'b0;
      ev_ferr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               shift_d    = tx_data;
               idle_cnt_d = '0;
               state_d    = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (!bus_in) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               idle_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = S_START;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         S_START: begin
            if (sample) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (sample) begin
               bit_cnt_d = '0;
               // A released '1' read back low means another node owns the line.
               if (shift_q[DATA_W-1] && !bus_in) begin
                  ev_lost = 1'b1;
                  state_d = S_IDLE;
               end else if (bit_idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = shift_q << 1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (sample) begin
               bit_cnt_d = '0;
               state_d   = S_IDLE;
               ev_done   = bus_in;
               ev_ferr   = !bus_in;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state so the registered values line up
   // with the state they belong to.
   always_comb begin
      tx_ready_d  = (state_d == S_IDLE);
      drive_d     = (state_d == S_START) ||
                    ((state_d == S_DATA) && !shift_d[DATA_W-1]);
      done_d      = ev_done;
      arb_lost_d  = ev_lost;
      frame_err_d = ev_ferr;
   end

   assign tx_ready      = tx_ready_q;
   assign bus_drive_low = drive_q;
   assign done          = done_q;
   assign arb_lost      = arb_lost_q;
   assign frame_err     = frame_err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_wand_bus_tx.sv
// Directed bench for wand_bus_tx: frame timing, arbitration, idle wait,
// stop-bit error, mid-frame reset and busy-time tx_valid.
module tb_wand_bus_tx;

   logic       clk;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       bus_in;
   logic       bus_drive_low;
   logic       done;
   logic       arb_lost;
   logic       frame_err;
   logic [2:0] state_dbg;
   logic       other_drive;
   logic       force_low;

   int total = 0;
   int bad   = 0;

   wand_bus_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .bus_in       (bus_in),
      .bus_drive_low(bus_drive_low),
      .done         (done),
      .arb_lost     (arb_lost),
      .frame_err    (frame_err),
      .state_dbg    (state_dbg)
   );

   assign bus_in = ~(bus_drive_low | other_drive | force_low);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offers d; on return the accept edge has passed and cycle 1 is running.
   task automatic accept(input logic [7:0] d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic test_reset;
      int got;
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'hC3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
      total++; if (bus_drive_low !== 1'b0) begin bad++; $display("FAIL reset_drive got=%b want=0", bus_drive_low); end
      total++; if ({done, arb_lost, frame_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {done, arb_lost, frame_err}); end
      total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
      rst_n = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      @(negedge clk);
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL first_edge_accept got=%b want=0", tx_ready); end
      total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL first_edge_state got=%0d want=1", state_dbg); end
      got = 0;
      for (int k = 2; k <= 60; k++) begin
         @(negedge clk);
         if (done === 1'b1 && got == 0) got = k;
      end
      total++; if (got != 45) begin bad++; $display("FAIL reset_frame_done_cycle got=%0d want=45", got); end
   endtask

   task automatic test_basic_frame(input logic [7:0] d);
      logic exp_drv;
      accept(d);
      for (int k = 1; k <= 46; k++) begin
         @(negedge clk);
         exp_drv = (k >= 5 && k <= 8) ? 1'b1 : (k >= 9 && k <= 40) ? ~d[7 - ((k - 9) / 4)] : 1'b0;
         total++; if (bus_drive_low !== exp_drv) begin bad++; $display("FAIL frame_%h_drive k=%0d got=%b want=%b", d, k, bus_drive_low, exp_drv); end
         total++; if (done !== (k == 45)) begin bad++; $display("FAIL frame_%h_done k=%0d got=%b want=%b", d, k, done, (k == 45)); end
         total++; if (tx_ready !== (k >= 45)) begin bad++; $display("FAIL frame_%h_ready k=%0d got=%b want=%b", d, k, tx_ready, (k >= 45)); end
         total++; if ({arb_lost, frame_err} !== 2'b00) begin bad++; $display("FAIL frame_%h_err k=%0d got=%b want=00", d, k, {arb_lost, frame_err}); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_arbitration;
      logic [7:0] mine  = 8'hA7;
      logic [7:0] other = 8'hA4;
      logic       exp_drv;
      accept(mine);
      for (int k = 1; k <= 46; k++) begin
         other_drive = (k >= 5 && k <= 8) ? 1'b1 : (k >= 9 && k <= 40) ? ~other[7 - ((k - 9) / 4)] : 1'b0;
         @(negedge clk);
         exp_drv = (k >= 5 && k <= 8) ? 1'b1 : (k >= 9 && k <= 36) ? ~mine[7 - ((k - 9) / 4)] : 1'b0;
         total++; if (bus_drive_low !== exp_drv) begin bad++; $display("FAIL arb_drive k=%0d got=%b want=%b", k, bus_drive_low, exp_drv); end
         total++; if (arb_lost !== (k == 37)) begin bad++; $display("FAIL arb_lost k=%0d got=%b want=%b", k, arb_lost, (k == 37)); end
         total++; if ({done, frame_err} !== 2'b00) begin bad++; $display("FAIL arb_no_done k=%0d got=%b want=00", k, {done, frame_err}); end
         if (k >= 37) begin
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL arb_ready k=%0d got=%b want=1", k, tx_ready); end
         end
         if (k >= 37 && k <= 44) begin
            total++; if (bus_in !== (k >= 41 ? 1'b1 : other[7 - ((k - 9) / 4)])) begin bad++; $display("FAIL arb_competitor_line k=%0d got=%b", k, bus_in); end
         end
         @(posedge clk);
         #1;
      end
      other_drive = 1'b0;
   endtask

   task automatic test_wait_idle;
      logic [7:0] d = 8'h0F;
      logic       exp_drv;
      logic [2:0] exp_st;
      force_low = 1'b1;
      accept(d);
      for (int k = 1; k <= 56; k++) begin
         force_low = (k <= 10);
         @(negedge clk);
         exp_drv = (k >= 15 && k <= 18) ? 1'b1 : (k >= 19 && k <= 50) ? ~d[7 - ((k - 19) / 4)] : 1'b0;
         total++; if (bus_drive_low !== exp_drv) begin bad++; $display("FAIL wait_drive k=%0d got=%b want=%b", k, bus_drive_low, exp_drv); end
         total++; if (done !== (k == 55)) begin bad++; $display("FAIL wait_done k=%0d got=%b want=%b", k, done, (k == 55)); end
         if (k >= 13 && k <= 15) begin
            exp_st = (k == 15) ? 3'd2 : 3'd1;
            total++; if (state_dbg !== exp_st) begin bad++; $display("FAIL wait_state k=%0d got=%0d want=%0d", k, state_dbg, exp_st); end
         end
         @(posedge clk);
         #1;
      end
      force_low = 1'b0;
   endtask

   task automatic test_stop_error;
      accept(8'hFF);
      for (int k = 1; k <= 47; k++) begin
         force_low = (k >= 41 && k <= 44);
         @(negedge clk);
         total++; if (frame_err !== (k == 45)) begin bad++; $display("FAIL stop_ferr k=%0d got=%b want=%b", k, frame_err, (k == 45)); end
         total++; if ({done, arb_lost} !== 2'b00) begin bad++; $display("FAIL stop_no_done k=%0d got=%b want=00", k, {done, arb_lost}); end
         if (k == 45) begin
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL stop_ready got=%b want=1", tx_ready); end
         end
         @(posedge clk);
         #1;
      end
      force_low = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [7:0] d = 8'h3C;
      logic       exp_drv;
      accept(d);
      for (int k = 1; k <= 30; k++) begin
         rst_n = (k != 22);
         @(negedge clk);
         exp_drv = (k >= 23) ? 1'b0 : (k >= 5 && k <= 8) ? 1'b1 : (k >= 9) ? ~d[7 - ((k - 9) / 4)] : 1'b0;
         total++; if (bus_drive_low !== exp_drv) begin bad++; $display("FAIL rstmid_drive k=%0d got=%b want=%b", k, bus_drive_low, exp_drv); end
         total++; if ({done, arb_lost, frame_err} !== 3'b000) begin bad++; $display("FAIL rstmid_pulses k=%0d got=%b want=000", k, {done, arb_lost, frame_err}); end
         if (k == 23) begin
            total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rstmid_state got=%0d want=0", state_dbg); end
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", tx_ready); end
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_busy_valid;
      logic [7:0] d = 8'h96;
      logic       exp_drv;
      accept(d);
      for (int k = 1; k <= 56; k++) begin
         tx_valid = (k <= 43) ? k[0] : 1'b0;
         tx_data  = k[1] ? 8'hFF : 8'h00;
         @(negedge clk);
         exp_drv = (k >= 5 && k <= 8) ? 1'b1 : (k >= 9 && k <= 40) ? ~d[7 - ((k - 9) / 4)] : 1'b0;
         total++; if (bus_drive_low !== exp_drv) begin bad++; $display("FAIL busy_drive k=%0d got=%b want=%b", k, bus_drive_low, exp_drv); end
         total++; if (done !== (k == 45)) begin bad++; $display("FAIL busy_done k=%0d got=%b want=%b", k, done, (k == 45)); end
         if (k >= 45) begin
            total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL busy_extra_frame k=%0d state=%0d want=0", k, state_dbg); end
         end
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      other_drive = 1'b0;
      force_low   = 1'b0;
      test_reset();
      test_basic_frame(8'hA5);
      test_arbitration();
      test_wait_idle();
      test_stop_error();
      test_reset_mid();
      test_basic_frame(8'h5A);
      test_busy_valid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
